// File: rtl/xor_checksum_unit_if.sv
// Word-in / result-out handshake bundle for xor_checksum_unit.
// The master modport faces the word source and result consumer; slave is the unit.
interface xor_checksum_unit_if #(
  parameter int WIDTH   = 16,
  parameter int MAX_LEN = 256
);
  localparam int CW = $clog2(MAX_LEN + 1);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_mode;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_count;
  logic             out_overflow;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, in_last, in_mode, out_ready,
    input  in_ready, out_data, out_count, out_overflow, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, in_mode, out_ready,
    output in_ready, out_data, out_count, out_overflow, out_valid
  );
endinterface

// File: rtl/xor_checksum_unit.sv
// Streaming XOR reduction over valid/ready packets: reports a WIDTH-bit checksum
// or a single parity bit, together with a saturating word count and overflow flag.
module xor_checksum_unit #(
  parameter int WIDTH   = 16,
  parameter int MAX_LEN = 256
) (
  input  logic              clk,
  input  logic              reset,
  xor_checksum_unit_if.slave bus
);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             mode_r;

  logic [WIDTH-1:0] res_data;
  logic [CW-1:0]    res_count;
  logic             res_ovf;

  logic             in_ready_c;
  logic             accept;
  logic             first;
  logic             sat;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             ovf_nxt;
  logic             mode_nxt;

  // Reset masks in_ready combinationally so no word is taken during reset.
  assign in_ready_c = !reset && (state != DONE);
  assign accept     = bus.in_valid && in_ready_c;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = bus.in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && bus.in_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Values the packet state takes if the current beat is accepted; the first
  // word of a packet restarts everything instead of folding into old state.
  always_comb begin
    first    = (state == IDLE);
    sat      = !first && (count == CW'(MAX_LEN));
    acc_nxt  = first ? bus.in_data : (acc ^ bus.in_data);
    mode_nxt = first ? bus.in_mode : mode_r;
    if (first) begin
      cnt_nxt = CW'(1);
    end else if (sat) begin
      cnt_nxt = count;
    end else begin
      cnt_nxt = count + CW'(1);
    end
    ovf_nxt = first ? 1'b0 : (ovf | sat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      mode_r    <= 1'b0;
      res_data  <= '0;
      res_count <= '0;
      res_ovf   <= 1'b0;
    end else if (accept) begin
      acc    <= acc_nxt;
      count  <= cnt_nxt;
      ovf    <= ovf_nxt;
      mode_r <= mode_nxt;
      if (bus.in_last) begin
        res_data  <= mode_nxt ? {{(WIDTH-1){1'b0}}, ^acc_nxt} : acc_nxt;
        res_count <= cnt_nxt;
        res_ovf   <= ovf_nxt;
      end
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = (state == DONE);
  assign bus.out_data     = res_data;
  assign bus.out_count    = res_count;
  assign bus.out_overflow = res_ovf;
endmodule

// File: tb/tb_xor_checksum_unit.sv
// Directed plus randomized bench for xor_checksum_unit (WIDTH=16, MAX_LEN=4),
// with a packet-level reference computed from the accepted word list.
module tb_xor_checksum_unit;
  localparam int WIDTH   = 16;
  localparam int MAX_LEN = 4;

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;

  xor_checksum_unit_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bus ();

  xor_checksum_unit #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and returns just after the edge that accepted it.
  task automatic send(input logic [WIDTH-1:0] data, input logic last, input logic mode);
    int n;
    bus.in_data  = data;
    bus.in_last  = last;
    bus.in_mode  = mode;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] x, input logic mode);
    if (mode) return WIDTH'($countones(x) % 2);
    return x;
  endfunction

  int               len;
  int               hold;
  logic             pmode;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] xr;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_out_ovf", 32'(bus.out_overflow), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Checksum, back-to-back words
    send(16'h00FF, 1'b0, 1'b0);
    send(16'h0F0F, 1'b0, 1'b0);
    send(16'hFFFF, 1'b1, 1'b0);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_data", 32'(bus.out_data), 32'hF00F);
    chk("t1_count", 32'(bus.out_count), 32'd3);
    chk("t1_ovf", 32'(bus.out_overflow), 32'd0);
    step();
    chk("t1_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("t1_ready_back", 32'(bus.in_ready), 32'd1);

    // Parity: mode taken from first word only
    send(16'h00FF, 1'b0, 1'b1);
    send(16'h0F0F, 1'b0, 1'b0);
    send(16'hFFFF, 1'b1, 1'b0);
    chk("t2a_data", 32'(bus.out_data), 32'h0000);
    chk("t2a_valid", 32'(bus.out_valid), 32'd1);
    step();
    send(16'h0001, 1'b0, 1'b1);
    send(16'h0003, 1'b1, 1'b0);
    chk("t2b_data", 32'(bus.out_data), 32'h0001);
    chk("t2b_count", 32'(bus.out_count), 32'd2);
    step();

    // Single-word packet
    send(16'h8001, 1'b1, 1'b0);
    chk("t3_data", 32'(bus.out_data), 32'h8001);
    chk("t3_count", 32'(bus.out_count), 32'd1);
    chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
    step();

    // Backpressure: result held, nothing consumed
    bus.out_ready = 1'b0;
    send(16'h00FF, 1'b0, 1'b0);
    send(16'h0F0F, 1'b0, 1'b0);
    send(16'hFFFF, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hDEAD;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid_hold", 32'(bus.out_valid), 32'd1);
      chk("t4_data_hold", 32'(bus.out_data), 32'hF00F);
      chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("t4_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("t4_ready_back", 32'(bus.in_ready), 32'd1);
    send(16'h1111, 1'b1, 1'b0);
    chk("t4_no_consume", 32'(bus.out_data), 32'h1111);
    chk("t4_no_consume_cnt", 32'(bus.out_count), 32'd1);
    step();

    // Overflow past MAX_LEN
    for (int i = 1; i <= 6; i++) begin
      send(WIDTH'(i), (i == 6), 1'b0);
    end
    chk("t5_data", 32'(bus.out_data), 32'h0007);
    chk("t5_count", 32'(bus.out_count), 32'd4);
    chk("t5_ovf", 32'(bus.out_overflow), 32'd1);
    step();

    // Reset mid-packet discards partial state
    send(16'hAAAA, 1'b0, 1'b0);
    send(16'h5555, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("t6_rst_data", 32'(bus.out_data), 32'd0);
    chk("t6_rst_count", 32'(bus.out_count), 32'd0);
    chk("t6_rst_ovf", 32'(bus.out_overflow), 32'd0);
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    send(16'h1234, 1'b1, 1'b0);
    chk("t6_data", 32'(bus.out_data), 32'h1234);
    chk("t6_count", 32'(bus.out_count), 32'd1);
    chk("t6_ovf", 32'(bus.out_overflow), 32'd0);
    step();

    // Randomized packets with gaps, mode noise and backpressure
    for (int p = 0; p < 30; p++) begin
      len   = $urandom_range(1, 7);
      pmode = 1'($urandom_range(0, 1));
      xr    = '0;
      for (int i = 0; i < len; i++) begin
        w  = WIDTH'($urandom);
        xr = xr ^ w;
        if ($urandom_range(0, 3) == 0) step();
        send(w, (i == len - 1), (i == 0) ? pmode : 1'($urandom_range(0, 1)));
      end
      chk("rnd_valid", 32'(bus.out_valid), 32'd1);
      chk("rnd_data", 32'(bus.out_data), 32'(ref_result(xr, pmode)));
      chk("rnd_count", 32'(bus.out_count), 32'((len > MAX_LEN) ? MAX_LEN : len));
      chk("rnd_ovf", 32'(bus.out_overflow), 32'(len > MAX_LEN));
      hold = $urandom_range(0, 2);
      bus.out_ready = (hold == 0);
      for (int h = 0; h < hold; h++) begin
        step();
        chk("rnd_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("rnd_hold_data", 32'(bus.out_data), 32'(ref_result(xr, pmode)));
      end
      bus.out_ready = 1'b1;
      step();
      chk("rnd_valid_drop", 32'(bus.out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
